// File: rtl/posit_field_extractor_pkg.sv
// Shared defaults and types for the posit field-extraction pipeline.
package posit_field_extractor_pkg;

    localparam int unsigned PositN  = 32;
    localparam int unsigned PositEs = 4;
    localparam int unsigned PositRs = $clog2(PositN);
    localparam int unsigned PositFw = PositN - PositEs - 3;

    typedef struct packed {
        logic                   sign;
        logic                   zero;
        logic                   nar;
        logic signed [PositRs:0] k;
        logic [PositEs-1:0]     exp;
        logic [PositFw:0]       mant;
    } decoded_posit_t;

    // Fraction bits left after sign, two regime bits and the exponent.
    function automatic int unsigned frac_width(int unsigned n, int unsigned es);
        return n - es - 3;
    endfunction

endpackage

// File: rtl/posit_field_extractor_if.sv
// Valid/ready bundle between the regime detector, the field extractor and the core.
interface posit_field_extractor_if
    import posit_field_extractor_pkg::*;
#(
    parameter int unsigned N  = PositN,
    parameter int unsigned ES = PositEs,
    parameter int unsigned RS = $clog2(N)
);
    localparam int unsigned FW = frac_width(N, ES);

    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic          in_zero;
    logic          in_nar;
    logic [N-2:0]  in_remain;
    logic [RS:0]   in_end_pos;
    logic          in_regime_check;

    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic          out_zero;
    logic          out_nar;
    logic [RS:0]   out_k;
    logic [ES-1:0] out_exp;
    logic [FW:0]   out_mant;

    modport master (
        output in_valid, in_sign, in_zero, in_nar, in_remain, in_end_pos, in_regime_check,
        output out_ready,
        input  in_ready,
        input  out_valid, out_sign, out_zero, out_nar, out_k, out_exp, out_mant
    );

    modport slave (
        input  in_valid, in_sign, in_zero, in_nar, in_remain, in_end_pos, in_regime_check,
        input  out_ready,
        output in_ready,
        output out_valid, out_sign, out_zero, out_nar, out_k, out_exp, out_mant
    );

endinterface

// File: rtl/posit_field_extractor_regime_shifter.sv
// Regime value k and the remainder shifted past the regime run and its terminator.
module posit_field_extractor_regime_shifter
    import posit_field_extractor_pkg::*;
#(
    parameter int unsigned N  = PositN,
    parameter int unsigned RS = $clog2(N)
) (
    input  logic [N-2:0] remain_i,
    input  logic [RS:0]  end_pos_i,
    input  logic         regime_check_i,
    output logic [RS:0]  k_o,
    output logic [N-4:0] fields_o
);
    localparam logic [RS:0] EndSat = (RS+1)'(N-1);

    logic [RS:0]  sh;
    logic [N-2:0] shifted;
    logic         unused_lsbs;

    always_comb begin
        // A run filling the whole word has no terminator to skip.
        sh      = (end_pos_i >= EndSat) ? EndSat : end_pos_i + (RS+1)'(1);
        k_o     = regime_check_i ? end_pos_i - (RS+1)'(1) : (RS+1)'(0) - end_pos_i;
        shifted = remain_i << sh;
    end

    assign fields_o    = shifted[N-2:2];
    assign unused_lsbs = ^shifted[1:0];

endmodule

// File: rtl/posit_field_extractor.sv
// Two-stage valid/ready decode: stage 1 strips the regime, stage 2 splits exponent and mantissa.
module posit_field_extractor
    import posit_field_extractor_pkg::*;
#(
    parameter int unsigned N  = PositN,
    parameter int unsigned ES = PositEs,
    parameter int unsigned RS = $clog2(N)
) (
    input logic                    clk,
    input logic                    reset,
    posit_field_extractor_if.slave bus
);
    localparam int unsigned FW = frac_width(N, ES);

    logic          s1_ready, s2_ready;
    logic          s1_valid_q, s2_valid_q;
    logic          s1_sign_q, s1_zero_q, s1_nar_q;
    logic [RS:0]   s1_k_q;
    logic [N-4:0]  s1_fields_q;
    logic [RS:0]   k_d;
    logic [N-4:0]  fields_d;

    logic          s2_sign_q, s2_zero_q, s2_nar_q;
    logic [RS:0]   s2_k_q, s2_k_d;
    logic [ES-1:0] s2_exp_q, s2_exp_d;
    logic [FW:0]   s2_mant_q, s2_mant_d;
    logic          special;

    posit_field_extractor_regime_shifter #(
        .N  (N),
        .RS (RS)
    ) u_regime_shifter (
        .remain_i       (bus.in_remain),
        .end_pos_i      (bus.in_end_pos),
        .regime_check_i (bus.in_regime_check),
        .k_o            (k_d),
        .fields_o       (fields_d)
    );

    assign s2_ready = !s2_valid_q || bus.out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;

    always_comb begin
        special   = s1_zero_q | s1_nar_q;
        s2_k_d    = special ? '0 : s1_k_q;
        s2_exp_d  = special ? '0 : s1_fields_q[N-4 -: ES];
        s2_mant_d = special ? '0 : {1'b1, s1_fields_q[FW-1:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            s1_k_q      <= '0;
            s1_fields_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_nar_q    <= 1'b0;
            s2_k_q      <= '0;
            s2_exp_q    <= '0;
            s2_mant_q   <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign_q   <= bus.in_sign;
                    s1_zero_q   <= bus.in_zero;
                    s1_nar_q    <= bus.in_nar;
                    s1_k_q      <= k_d;
                    s1_fields_q <= fields_d;
                end
            end
            // Data only moves on a real handover so a stalled output stays stable.
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_sign_q <= s1_sign_q;
                    s2_zero_q <= s1_zero_q;
                    s2_nar_q  <= s1_nar_q;
                    s2_k_q    <= s2_k_d;
                    s2_exp_q  <= s2_exp_d;
                    s2_mant_q <= s2_mant_d;
                end
            end
        end
    end

    assign bus.in_ready  = s1_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_sign  = s2_sign_q;
    assign bus.out_zero  = s2_zero_q;
    assign bus.out_nar   = s2_nar_q;
    assign bus.out_k     = s2_k_q;
    assign bus.out_exp   = s2_exp_q;
    assign bus.out_mant  = s2_mant_q;

    m_nonzero_a : assert property (@(posedge clk) disable iff (reset)
        bus.in_valid |-> (bus.in_end_pos != '0));

endmodule

// File: tb/tb_posit_field_extractor.sv
// Randomized and directed checks of the field extractor against an arithmetic posit model.
module tb_posit_field_extractor;

    localparam int unsigned N  = 8;
    localparam int unsigned ES = 1;
    localparam int unsigned FW = N - ES - 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    posit_field_extractor_if #(.N(N), .ES(ES)) bus ();

    posit_field_extractor #(.N(N), .ES(ES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int word;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    bit   last_acc;
    bit   last_out;
    int   last_word;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packed as {sign, zero, nar, k[3:0], exp, mant[4:0]}.
    function automatic int model(int rem, int m, bit rc, bit z, bit n, bit s);
        int sh, shv, e, frac, mant, k;
        sh   = (m + 1 < N - 1) ? m + 1 : N - 1;
        shv  = (rem * (2 ** sh)) % (2 ** (N - 1));
        e    = shv / (2 ** (N - 1 - ES));
        frac = (shv / 4) % (2 ** FW);
        k    = rc ? m - 1 : -m;
        if (z || n) begin
            k    = 0;
            e    = 0;
            mant = 0;
        end else begin
            mant = (2 ** FW) + frac;
        end
        return (int'(s) << 12) | (int'(z) << 11) | (int'(n) << 10) | ((k & 15) << 6)
               | (e << 5) | mant;
    endfunction

    function automatic int dut_word();
        return int'({bus.out_sign, bus.out_zero, bus.out_nar, bus.out_k, bus.out_exp,
                     bus.out_mant});
    endfunction

    task automatic cycle(input bit v, input int rem, input int m, input bit rc, input bit z,
                         input bit n, input bit s, input bit ordy);
        @(negedge clk);
        bus.in_valid        = v;
        bus.in_remain       = 7'(rem);
        bus.in_end_pos      = 4'(m);
        bus.in_regime_check = rc;
        bus.in_zero         = z;
        bus.in_nar          = n;
        bus.in_sign         = s;
        bus.out_ready       = ordy;
        #1;
        last_acc = v && bus.in_ready;
        last_out = bus.out_valid;
        if (bus.out_valid) begin
            last_word = dut_word();
            if (sb.size() == 0) begin
                check_eq("spurious_out_valid", int'(bus.out_valid), 0);
            end else begin
                check_eq("out_word", last_word, sb[0].word);
                if (ordy) void'(sb.pop_front());
            end
        end
        if (last_acc) sb.push_back('{model(rem, m, rc, z, n, s), cyc});
        cyc++;
    endtask

    task automatic rand_cycle(input bit v, input bit ordy);
        cycle(v, int'($urandom_range(127, 0)), int'($urandom_range(7, 1)),
              1'($urandom_range(1, 0)), $urandom_range(15, 0) == 0,
              $urandom_range(15, 0) == 0, 1'($urandom_range(1, 0)), ordy);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            cycle(0, 0, 1, 0, 0, 0, 0, 1);
            n++;
        end
        check_eq("drain_empty", sb.size(), 0);
        repeat (2) cycle(0, 0, 1, 0, 0, 0, 0, 1);
    endtask

    task automatic directed(input string tag, input int rem, input int m, input bit rc,
                            input bit z, input int k_exp, input int e_exp, input int mant_exp,
                            input int zero_exp);
        int waited = 0;
        cycle(1, rem, m, rc, z, 0, 0, 1);
        check_eq({tag, "_accept"}, int'(last_acc), 1);
        do begin
            cycle(0, 0, 1, 0, 0, 0, 0, 1);
            waited++;
        end while (!last_out && waited < 6);
        check_eq({tag, "_latency"}, waited, 2);
        check_eq({tag, "_k"}, (last_word >> 6) & 15, k_exp & 15);
        check_eq({tag, "_exp"}, (last_word >> 5) & 1, e_exp);
        check_eq({tag, "_mant"}, last_word & 31, mant_exp);
        check_eq({tag, "_zero"}, (last_word >> 11) & 1, zero_exp);
    endtask

    initial begin
        bit saw_stall;
        int sent, first, last, cnt;

        bus.in_valid        = 1'b0;
        bus.in_remain       = '0;
        bus.in_end_pos      = 4'd1;
        bus.in_regime_check = 1'b0;
        bus.in_zero         = 1'b0;
        bus.in_nar          = 1'b0;
        bus.in_sign         = 1'b0;
        bus.out_ready       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("reset_out_valid", int'(bus.out_valid), 0);
        check_eq("reset_out_word", dut_word(), 0);
        check_eq("reset_in_ready", int'(bus.in_ready), 1);

        directed("t1", 7'b1101011, 2, 1, 0, 1, 1, 5'b10110, 0);
        directed("t2", 7'b0001101, 3, 0, 0, -3, 1, 5'b10100, 0);
        directed("t3_sat", 7'b1111111, 7, 1, 0, 6, 0, 5'b10000, 0);
        directed("t3_zero", 7'b0000000, 7, 0, 1, 0, 0, 0, 1);
        drain();

        // Backpressure: output stalled on relative cycles 3..5.
        saw_stall = 0;
        sent      = 0;
        for (int i = 0; i < 12; i++) begin
            rand_cycle(sent < 4, !(i >= 3 && i <= 5));
            if (sent < 4 && !last_acc) saw_stall = 1;
            if (last_acc) sent++;
        end
        check_eq("bp_in_ready_dropped", int'(saw_stall), 1);
        check_eq("bp_words_sent", sent, 4);
        drain();

        // Back-to-back stream, no bubbles.
        first = -1;
        last  = -1;
        cnt   = 0;
        for (int i = 0; i < 12; i++) begin
            rand_cycle(i < 8, 1'b1);
            if (i < 8) check_eq("b2b_accept", int'(last_acc), 1);
            if (last_out) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        check_eq("b2b_count", cnt, 8);
        check_eq("b2b_first", first, 2);
        check_eq("b2b_span", last - first, 7);
        drain();

        // Reset with two words in flight.
        rand_cycle(1'b1, 1'b1);
        rand_cycle(1'b1, 1'b1);
        @(negedge clk);
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_mid_out_valid", int'(bus.out_valid), 0);
        check_eq("rst_mid_out_word", dut_word(), 0);
        check_eq("rst_mid_in_ready", int'(bus.in_ready), 1);
        sb.delete();
        directed("t6_after_rst", 7'b1101011, 2, 1, 0, 1, 1, 5'b10110, 0);
        drain();

        for (int i = 0; i < 300; i++) begin
            rand_cycle($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
